// File: rtl/plic_cc_arb.sv
// Round-robin arbiter that shares one plic_core claim/complete port among TGT_NUM targets.
// One transaction at a time: grant, claim/complete strobe, settle wait, then a one-hot response.
module plic_cc_arb #(
  parameter int unsigned TGT_NUM    = 4,
  parameter int unsigned IRQ_WIDTH  = 5,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [TGT_NUM-1:0]             req_i,
  input  logic [TGT_NUM-1:0]             req_comp_i,
  input  logic [TGT_NUM*IRQ_WIDTH-1:0]   req_id_i,
  output logic [TGT_NUM-1:0]             gnt_o,
  output logic [TGT_NUM-1:0]             rsp_vld_o,
  output logic [IRQ_WIDTH-1:0]           rsp_id_o,
  input  logic                           core_irq_i,
  input  logic [IRQ_WIDTH-1:0]           core_id_i,
  output logic                           clam_o,
  output logic                           comp_o,
  output logic [IRQ_WIDTH-1:0]           comp_id_o,
  output logic                           busy_o
);

  localparam int unsigned PTR_W = (TGT_NUM > 1) ? $clog2(TGT_NUM) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CLAIM,
    COMP,
    SETTLE,
    RESP
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     last_q, last_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [IRQ_WIDTH-1:0] req_id_q, req_id_d;
  logic [IRQ_WIDTH-1:0] rsp_id_q, rsp_id_d;

  logic                 pick_vld;
  logic [PTR_W-1:0]     pick_idx;
  int unsigned          cand;

  // Search begins one past the last grantee and wraps without a modulo operator.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int unsigned i = 1; i <= TGT_NUM; i++) begin
      cand = 32'(last_q) + i;
      if (cand >= TGT_NUM) cand = cand - TGT_NUM;
      if (!pick_vld && req_i[PTR_W'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    req_id_d  = req_id_q;
    rsp_id_d  = rsp_id_q;
    gnt_o     = '0;
    rsp_vld_o = '0;
    rsp_id_o  = '0;
    clam_o    = 1'b0;
    comp_o    = 1'b0;
    comp_id_o = '0;
    unique case (state_q)
      IDLE: begin
        // gnt_o is combinational, so it is masked while reset is held.
        if (pick_vld && !rst_i) begin
          gnt_o[pick_idx] = 1'b1;
          last_d          = pick_idx;
          req_id_d        = req_id_i[32'(pick_idx)*IRQ_WIDTH +: IRQ_WIDTH];
          state_d         = req_comp_i[pick_idx] ? COMP : CLAIM;
        end
      end
      CLAIM: begin
        if (core_irq_i) begin
          clam_o   = 1'b1;
          rsp_id_d = core_id_i;
        end else begin
          rsp_id_d = '0;
        end
        cnt_d   = 3'(SETTLE_CYC - 1);
        state_d = SETTLE;
      end
      COMP: begin
        comp_o    = 1'b1;
        comp_id_o = req_id_q;
        rsp_id_d  = req_id_q;
        cnt_d     = 3'(SETTLE_CYC - 1);
        state_d   = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        rsp_vld_o[last_q] = 1'b1;
        rsp_id_o          = rsp_id_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_q   <= PTR_W'(TGT_NUM - 1);
      cnt_q    <= '0;
      req_id_q <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      req_id_q <= req_id_d;
      rsp_id_q <= rsp_id_d;
    end
  end

endmodule

// File: tb/tb_plic_cc_arb.sv
// Bench for plic_cc_arb: transaction-level model compared every cycle, directed
// scenarios with literal expectations, then randomized mixed claim/complete traffic.
module tb_plic_cc_arb;

  localparam int T  = 4;
  localparam int IW = 5;
  localparam int SC = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [T-1:0]    req = '0, req_comp = '0;
  logic [T*IW-1:0] req_id = '0;
  logic            core_irq = 1'b0;
  logic [IW-1:0]   core_id = '0;
  logic [T-1:0]    gnt, rsp_vld;
  logic [IW-1:0]   rsp_id, comp_id;
  logic            clam, comp, busy;

  // Next-cycle stimulus, applied just after the rising edge
  logic            n_rst = 1'b1;
  logic [T-1:0]    n_req = '0, n_req_comp = '0;
  logic [T*IW-1:0] n_req_id = '0;
  logic            n_core_irq = 1'b0;
  logic [IW-1:0]   n_core_id = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one outstanding transaction tracked by cycles elapsed since its grant
  bit          m_active = 1'b0;
  int          m_last   = T - 1;
  int          m_k, m_tgt;
  bit          m_comp;
  logic [IW-1:0] m_id, m_rsp;
  logic [T-1:0]  last_egnt = '0;

  plic_cc_arb #(.TGT_NUM(T), .IRQ_WIDTH(IW), .SETTLE_CYC(SC)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_comp_i(req_comp), .req_id_i(req_id),
    .gnt_o(gnt), .rsp_vld_o(rsp_vld), .rsp_id_o(rsp_id),
    .core_irq_i(core_irq), .core_id_i(core_id),
    .clam_o(clam), .comp_o(comp), .comp_id_o(comp_id), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    logic [T-1:0]  e_gnt, e_vld;
    logic [IW-1:0] e_rid, e_cid;
    logic          e_clam, e_comp, e_busy;
    int            pick, c;
    @(posedge clk);
    #1;
    rst = n_rst; req = n_req; req_comp = n_req_comp; req_id = n_req_id;
    core_irq = n_core_irq; core_id = n_core_id;
    @(negedge clk);
    e_gnt = '0; e_vld = '0; e_rid = '0; e_cid = '0;
    e_clam = 1'b0; e_comp = 1'b0; e_busy = 1'b0;
    pick = -1;
    if (rst) begin
      m_active = 1'b0;
      m_last   = T - 1;
    end else if (!m_active) begin
      for (int i = 1; i <= T; i++) begin
        c = (m_last + i) % T;
        if (pick < 0 && req[c]) pick = c;
      end
      if (pick >= 0) begin
        e_gnt[pick] = 1'b1;
        m_active = 1'b1;
        m_k      = 0;
        m_tgt    = pick;
        m_comp   = req_comp[pick];
        m_id     = req_id[pick*IW +: IW];
        m_last   = pick;
      end
    end else begin
      e_busy = 1'b1;
      m_k++;
      if (m_k == 1) begin
        if (m_comp) begin
          e_comp = 1'b1;
          e_cid  = m_id;
          m_rsp  = m_id;
        end else begin
          e_clam = core_irq;
          m_rsp  = core_irq ? core_id : '0;
        end
      end
      if (m_k == SC + 2) begin
        e_vld[m_tgt] = 1'b1;
        e_rid        = m_rsp;
        m_active     = 1'b0;
      end
    end
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("rsp_vld", 32'(rsp_vld), 32'(e_vld));
    chk("rsp_id", 32'(rsp_id), 32'(e_rid));
    chk("clam", 32'(clam), 32'(e_clam));
    chk("comp", 32'(comp), 32'(e_comp));
    chk("comp_id", 32'(comp_id), 32'(e_cid));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("strobe_excl", 32'(clam & comp), 32'd0);
    last_egnt = e_gnt;
  endtask

  logic [T-1:0]  pend, pcomp;
  logic [IW-1:0] pid [T];

  initial begin
    // Reset state
    step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    n_rst = 1'b0;
    step();

    // Single claim with pending irq 7
    n_req = 4'b0001; n_core_irq = 1'b1; n_core_id = 5'd7;
    step(); chk("claim_gnt_c0", 32'(gnt), 32'h1);
    n_req = '0;
    step(); chk("claim_clam_c1", 32'(clam), 32'h1);
    step(); step();
    step(); chk("claim_vld_c4", 32'(rsp_vld), 32'h1); chk("claim_id_c4", 32'(rsp_id), 32'd7);

    // Claim with nothing pending
    n_req = 4'b0001; n_core_irq = 1'b0; n_core_id = 5'd9;
    step(); chk("noirq_gnt_c0", 32'(gnt), 32'h1);
    n_req = '0;
    step(); chk("noirq_clam_c1", 32'(clam), 32'h0);
    step(); step();
    step(); chk("noirq_vld_c4", 32'(rsp_vld), 32'h1); chk("noirq_id_c4", 32'(rsp_id), 32'd0);

    // Complete of ID 5 from target 2
    n_req = 4'b0100; n_req_comp = 4'b0100; n_req_id = '0; n_req_id[2*IW +: IW] = 5'd5;
    step(); chk("comp_gnt_c0", 32'(gnt), 32'h4);
    n_req = '0; n_req_comp = '0;
    step(); chk("comp_c1", 32'(comp), 32'h1); chk("comp_id_c1", 32'(comp_id), 32'd5);
    step(); step();
    step(); chk("comp_vld_c4", 32'(rsp_vld), 32'h4); chk("comp_rid_c4", 32'(rsp_id), 32'd5);

    // Complete of ID 0 still forwarded and echoed
    n_req = 4'b1000; n_req_comp = 4'b1000; n_req_id = '0;
    step(); chk("comp0_gnt", 32'(gnt), 32'h8);
    n_req = '0; n_req_comp = '0;
    step(); chk("comp0_strobe", 32'(comp), 32'h1);
    step(); step(); step();

    // Fairness from a fresh reset: all four held
    n_rst = 1'b1; step(); n_rst = 1'b0; step();
    n_req = 4'b1111; n_core_irq = 1'b1; n_core_id = 5'd3;
    for (int i = 0; i <= 20; i++) begin
      step();
      if (i % 5 == 0) chk("fair_gnt", 32'(gnt), 32'(1 << ((i / 5) % 4)));
    end
    n_req = '0;
    repeat (5) step();

    // Reset in the middle of a claim
    n_req = 4'b0001;
    step(); chk("abort_gnt", 32'(gnt), 32'h1);
    n_req = '0;
    step();
    n_rst = 1'b1;
    step(); chk("abort_busy", 32'(busy), 32'h0); chk("abort_vld", 32'(rsp_vld), 32'h0);
    n_rst = 1'b0; n_req = 4'b0010;
    step(); chk("after_rst_gnt", 32'(gnt), 32'h2);
    n_req = '0;
    repeat (5) step();

    // Randomized mixed traffic
    pend = '0; pcomp = '0;
    for (int t = 0; t < T; t++) pid[t] = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int t = 0; t < T; t++) begin
        if (pend[t] && last_egnt[t]) pend[t] = 1'b0;
        else if (pend[t] && $urandom_range(99) < 3) pend[t] = 1'b0;
        else if (!pend[t] && $urandom_range(99) < 25) begin
          pend[t]  = 1'b1;
          pcomp[t] = 1'($urandom_range(1));
          pid[t]   = IW'($urandom_range(31));
        end
        n_req_id[t*IW +: IW] = pid[t];
      end
      n_req      = pend;
      n_req_comp = pcomp;
      n_core_irq = 1'($urandom_range(1));
      n_core_id  = IW'($urandom_range(31));
      n_rst      = ($urandom_range(999) < 2);
      if (n_rst) pend = '0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
